// File: rtl/bj_hazard_ctrl.sv
// Hazard/stall sequencer beside the ID-stage branch/jump resolver: bubble countdown FSM, flush gating, memory freeze.
// Optional performance counters (stall_cycles, flush_count) are built only when HAZARD_PERF_CNT_EN is defined.
module bj_hazard_ctrl #(
  parameter int RADDR_WIDTH = 5,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_branch_jump,
  input  logic                   id_reg_read1,
  input  logic                   id_reg_read2,
  input  logic [RADDR_WIDTH-1:0] id_reg_rs1,
  input  logic [RADDR_WIDTH-1:0] id_reg_rs2,
  input  logic                   idex_reg_write,
  input  logic                   idex_mem_read,
  input  logic [RADDR_WIDTH-1:0] idex_reg_dest,
  input  logic                   exmem_mem_read,
  input  logic [RADDR_WIDTH-1:0] exmem_reg_dest,
  input  logic                   flush_req,
  input  logic                   mem_busy,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic                   pipe_freeze,
  output logic [CNT_WIDTH-1:0]   stall_cycles,
  output logic [CNT_WIDTH-1:0]   flush_count
`else
  output logic                   pipe_freeze
`endif
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [1:0] need;
  logic       match_ex, match_mem_ld, stall;

  // x0 is never a real producer, so a zero rd can never create a hazard.
  always_comb begin
    match_ex = idex_reg_write && (idex_reg_dest != '0) &&
               ((id_reg_read1 && (id_reg_rs1 == idex_reg_dest)) ||
                (id_reg_read2 && (id_reg_rs2 == idex_reg_dest)));
    match_mem_ld = exmem_mem_read && (exmem_reg_dest != '0) &&
                   ((id_reg_read1 && (id_reg_rs1 == exmem_reg_dest)) ||
                    (id_reg_read2 && (id_reg_rs2 == exmem_reg_dest)));
  end

  always_comb begin
    need = 2'd0;
    if (id_branch_jump && match_ex && idex_mem_read)
      need = 2'd2;
    else if ((id_branch_jump && (match_ex || match_mem_ld)) ||
             (!id_branch_jump && match_ex && idex_mem_read))
      need = 2'd1;
  end

  // Once in HOLD the countdown alone decides; `need` is only sampled in RUN.
  assign stall = (state_q == HOLD) || (need != 2'd0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (!mem_busy) begin
      case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            rem_d   = need - 2'd1;
            state_d = (need > 2'd1) ? HOLD : RUN;
          end
        end
        HOLD: begin
          if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = RUN;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        default: begin
          rem_d   = 2'd0;
          state_d = RUN;
        end
      endcase
    end
  end

  // Freeze outranks everything; flush waits until operands are valid.
  always_comb begin
    pc_stall    = !rst && (mem_busy || stall);
    ifid_stall  = !rst && (mem_busy || stall);
    idex_bubble = !rst && !mem_busy && stall;
    pipe_freeze = !rst && mem_busy;
    ifid_flush  = !rst && flush_req && !stall && !mem_busy;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pc_stall)   stall_cycles_d = stall_cycles_q + 1'b1;
    if (ifid_flush) flush_count_d  = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_bj_hazard_ctrl.sv
// Directed bench for bj_hazard_ctrl: load-use, branch operand hazards, flush gating, freeze and async reset.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_bj_hazard_ctrl;

  logic       clk, rst;
  logic       id_branch_jump, id_reg_read1, id_reg_read2;
  logic [4:0] id_reg_rs1, id_reg_rs2;
  logic       idex_reg_write, idex_mem_read;
  logic [4:0] idex_reg_dest;
  logic       exmem_mem_read;
  logic [4:0] exmem_reg_dest;
  logic       flush_req, mem_busy;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  bj_hazard_ctrl #(.RADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_branch_jump (id_branch_jump),
    .id_reg_read1   (id_reg_read1),
    .id_reg_read2   (id_reg_read2),
    .id_reg_rs1     (id_reg_rs1),
    .id_reg_rs2     (id_reg_rs2),
    .idex_reg_write (idex_reg_write),
    .idex_mem_read  (idex_mem_read),
    .idex_reg_dest  (idex_reg_dest),
    .exmem_mem_read (exmem_mem_read),
    .exmem_reg_dest (exmem_reg_dest),
    .flush_req      (flush_req),
    .mem_busy       (mem_busy),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .pipe_freeze    (pipe_freeze),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`else
    .pipe_freeze    (pipe_freeze)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_pc, input logic e_fl,
                         input logic e_bub, input logic e_frz);
    chk1({tag, ".pc_stall"},    pc_stall,    e_pc);
    chk1({tag, ".ifid_stall"},  ifid_stall,  e_pc);
    chk1({tag, ".ifid_flush"},  ifid_flush,  e_fl);
    chk1({tag, ".idex_bubble"}, idex_bubble, e_bub);
    chk1({tag, ".pipe_freeze"}, pipe_freeze, e_frz);
  endtask

  // One cycle: drive inputs after the falling edge, check before the next rising edge.
  task automatic step(input string tag,
                      input logic bj, input logic r1, input logic [4:0] rs1,
                      input logic r2, input logic [4:0] rs2,
                      input logic ew, input logic eld, input logic [4:0] erd,
                      input logic mld, input logic [4:0] mrd,
                      input logic fl, input logic bz,
                      input logic e_pc, input logic e_fl, input logic e_bub, input logic e_frz);
    @(negedge clk);
    id_branch_jump = bj;  id_reg_read1 = r1;  id_reg_rs1 = rs1;
    id_reg_read2   = r2;  id_reg_rs2   = rs2;
    idex_reg_write = ew;  idex_mem_read = eld; idex_reg_dest = erd;
    exmem_mem_read = mld; exmem_reg_dest = mrd;
    flush_req      = fl;  mem_busy = bz;
    #1;
    chk_out(tag, e_pc, e_fl, e_bub, e_frz);
  endtask

  initial begin
    rst = 1'b1;
    id_branch_jump = 0; id_reg_read1 = 0; id_reg_read2 = 0;
    id_reg_rs1 = 0; id_reg_rs2 = 0;
    idex_reg_write = 0; idex_mem_read = 0; idex_reg_dest = 0;
    exmem_mem_read = 0; exmem_reg_dest = 0;
    flush_req = 0; mem_busy = 0;

    // Reset: outputs stay low even with a hazard and flush request present
    step("rst_hazard", 1,1,5,1,6, 1,1,5, 0,0, 1,0,  0,0,0,0);
    step("rst_idle",   0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);
`ifdef HAZARD_PERF_CNT_EN
    chk32("rst_cnt_stall", stall_cycles, 0);
    chk32("rst_cnt_flush", flush_count, 0);
`endif
    rst = 1'b0;

    // EX: lw x5, ID: beq x5,x6 -> two bubbles, flush held off, resolves on third cycle
    step("lw_beq_c1",  1,1,5,1,6, 1,1,5, 0,0, 1,0,  1,0,1,0);
    step("lw_beq_c2",  1,1,5,1,6, 0,0,0, 1,5, 1,0,  1,0,1,0);
    step("lw_beq_c3",  1,1,5,1,6, 0,0,0, 0,0, 1,0,  0,1,0,0);
    step("idle1",      0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);

    // EX: add x7, ID: bne x7,x0 -> one bubble, then flush with PC free
    step("add_bne_c1", 1,1,7,1,0, 1,0,7, 0,0, 1,0,  1,0,1,0);
    step("add_bne_c2", 1,1,7,1,0, 0,0,0, 0,0, 1,0,  0,1,0,0);

    // Load-use for ordinary instructions
    step("ld_use_c1",  0,1,3,1,1, 1,1,3, 0,0, 0,0,  1,0,1,0);
    step("ld_use_c2",  0,1,3,1,1, 0,0,0, 1,3, 0,0,  0,0,0,0);
    step("ld_x0",      0,1,0,1,1, 1,1,0, 0,0, 0,0,  0,0,0,0);
    step("rs2_unused", 0,1,4,0,3, 1,1,3, 0,0, 0,0,  0,0,0,0);
    step("rs2_used",   0,1,4,1,3, 1,1,3, 0,0, 0,0,  1,0,1,0);
    step("bj_mem_ld",  1,1,9,1,8, 0,0,0, 1,8, 0,0,  1,0,1,0);
    step("alu_nonbj",  0,1,7,0,0, 1,0,7, 0,0, 1,0,  0,1,0,0);
    step("idle2",      0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);

    // Freeze in the middle of a two-bubble stall; one bubble remains after release
    step("frz_c1",     1,1,5,1,6, 1,1,5, 0,0, 0,0,  1,0,1,0);
    step("frz_busy1",  1,1,5,1,6, 1,1,5, 0,0, 1,1,  1,0,0,1);
    step("frz_busy2",  1,1,5,1,6, 1,1,5, 0,0, 1,1,  1,0,0,1);
    step("frz_busy3",  1,1,5,1,6, 1,1,5, 0,0, 1,1,  1,0,0,1);
    step("frz_rel",    0,0,0,0,0, 0,0,0, 0,0, 0,0,  1,0,1,0);
    step("frz_done",   0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);
    step("busy_run",   0,0,0,0,0, 0,0,0, 0,0, 1,1,  1,0,0,1);
    step("idle3",      0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);

    // Reset while HOLD is frozen: without the reset HOLD would survive into the next cycle
    step("rh_c1",      1,1,5,1,6, 1,1,5, 0,0, 0,0,  1,0,1,0);
    step("rh_busy",    1,1,5,1,6, 1,1,5, 0,0, 1,1,  1,0,0,1);
    rst = 1'b1;
    #1;
    chk_out("rh_async", 0,0,0,0);
`ifdef HAZARD_PERF_CNT_EN
    chk32("rh_cnt_stall", stall_cycles, 0);
    chk32("rh_cnt_flush", flush_count, 0);
`endif
    step("rh_in_rst",  0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);
    rst = 1'b0;
    step("rh_run",     0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);

    // Four stall cycles and two flush cycles
    step("pc_c1",      1,1,5,1,6, 1,1,5, 0,0, 0,0,  1,0,1,0);
    step("pc_c2",      0,0,0,0,0, 0,0,0, 0,0, 0,0,  1,0,1,0);
    step("pc_c3",      1,1,7,1,0, 1,0,7, 0,0, 0,0,  1,0,1,0);
    step("pc_c4",      0,1,3,1,1, 1,1,3, 0,0, 0,0,  1,0,1,0);
    step("pc_fl1",     0,0,0,0,0, 0,0,0, 0,0, 1,0,  0,1,0,0);
    step("pc_fl2",     0,0,0,0,0, 0,0,0, 0,0, 1,0,  0,1,0,0);
    step("pc_end",     0,0,0,0,0, 0,0,0, 0,0, 0,0,  0,0,0,0);
`ifdef HAZARD_PERF_CNT_EN
    chk32("cnt_stall", stall_cycles, 4);
    chk32("cnt_flush", flush_count, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bj_hazard_ctrl.md
Name: bj_hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the ID-stage branch/jump resolver.
- Detects when the instruction in ID needs a register value that is not yet forwardable (load-use, or branch operands still in EX, or load data still in MEM).
- Inserts the required number of bubbles with a registered countdown FSM, gates the resolver's flush while operands are invalid, and freezes the whole pipe on external memory wait.
- Sits beside the ID stage and drives stall/flush/bubble enables of the PC, IF/ID and ID/EX registers.

Parameters:
- RADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, width of the optional performance counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- id_branch_jump  in  1  instruction in ID is a branch or jump
- id_reg_read1  in  1  ID instruction reads rs1
- id_reg_read2  in  1  ID instruction reads rs2
- id_reg_rs1  in  RADDR_WIDTH  rs1 of the ID instruction
- id_reg_rs2  in  RADDR_WIDTH  rs2 of the ID instruction
- idex_reg_write  in  1  EX instruction writes rd
- idex_mem_read  in  1  EX instruction is a load
- idex_reg_dest  in  RADDR_WIDTH  EX rd
- exmem_mem_read  in  1  MEM instruction is a load
- exmem_reg_dest  in  RADDR_WIDTH  MEM rd
- flush_req  in  1  flush request from the branch/jump resolver
- mem_busy  in  1  instruction or data memory wait, freeze request
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID register to NOP
- idex_bubble  out  1  load NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
- stall_cycles  out  CNT_WIDTH  only present with the optional feature
- flush_count  out  CNT_WIDTH  only present with the optional feature

Behaviour:
- Matches use rd != x0. The match for rs1 is qualified by id_reg_read1; the match for rs2 is qualified by id_reg_read2.
- match_ex: idex_reg_write, and idex_reg_dest equals a used source.
- match_mem_ld: exmem_mem_read, and exmem_reg_dest equals a used source.
- Required bubble count `need`, computed combinationally:
  - id_branch_jump and match_ex and idex_mem_read: 2.
  - id_branch_jump and match_ex and not idex_mem_read: 1.
  - id_branch_jump and match_mem_ld: 1.
  - Not id_branch_jump and match_ex and idex_mem_read (load-use): 1.
  - Otherwise: 0. The maximum is taken if several conditions apply.
- FSM states: RUN, HOLD (2-bit remaining counter `rem`).
  - RUN, need = 0: no stall, next state RUN.
  - RUN, need > 0: stall this cycle, rem <= need-1; next state HOLD if need-1 > 0, else RUN.
  - HOLD: stall this cycle, rem <= rem-1; return to RUN when rem reaches 0. The `need` value is ignored in HOLD because the FSM is authoritative.
- Stall cycle outputs: pc_stall=1, ifid_stall=1, idex_bubble=1.
- Outputs are combinational from the registered state and current inputs. Bubble latency is 0 cycles from detection.
- Flush: ifid_flush = flush_req & ~stall & ~mem_busy. Operands are not valid during a stall, so the flush is suppressed.
  - An ifid_flush cycle with no stall does not assert pc_stall; the PC loads the target.
- Freeze, mem_busy=1:
  - pc_stall=1, ifid_stall=1, pipe_freeze=1, idex_bubble=0, ifid_flush=0.
  - FSM state and rem hold.
  - Highest priority.
- Reset (async, any time, including mid-HOLD): state RUN, rem 0. All outputs are 0 while rst is high; counters clear to 0.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both counters wrap at 2^CNT_WIDTH.
- When undefined: both ports and their counter logic are absent. All other behaviour is identical.

Test Plan:
- EX: lw x5; ID: beq x5,x6 -> exactly 2 consecutive stall cycles with idex_bubble=1 and ifid_flush=0 during both; the branch resolves on the 3rd cycle.
- EX: add x7; ID: bne x7,x0 -> 1 stall cycle, then flush_req=1 yields ifid_flush=1 with pc_stall=0.
- EX: lw x3; ID: add x4,x3,x1 -> 1 stall. The same with ID: add x4,x0,x1 and x0 as the load rd -> 0 stalls.
- 2-bubble stall starts, then mem_busy=1 for 3 cycles during HOLD -> pipe_freeze=1, idex_bubble=0, rem held; after release exactly 1 more stall cycle.
- rst pulsed while in HOLD -> all outputs 0 immediately, state RUN; with HAZARD_PERF_CNT_EN, counters read 0.
- With HAZARD_PERF_CNT_EN: 4 stall cycles and 2 flushes -> stall_cycles=4, flush_count=2.
